// File: rtl/shredder_frame_sequencer.sv
// shredder_frame_sequencer
// Runs one Life generation: streams the current frame row by row through
// shredder_array, adds a zero padding row below the frame, and writes each
// next-state row into the next-frame RAM. One start pulse = one generation.
module shredder_frame_sequencer #(
   parameter int WIDTH  = 32,
   parameter int HEIGHT = 32,
   parameter int ADDR_W = 5,
   parameter int LAT    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [WIDTH-1:0]  rd_data,
   output logic              arr_rst,
   output logic [WIDTH-1:0]  arr_in,
   input  logic [WIDTH-1:0]  arr_out,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [WIDTH-1:0]  wr_data
);

   localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(HEIGHT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FEED,
      S_FLUSH,
      S_DONE
   } state_t;

   state_t state;

   // Row currently on arr_in (RAM data is valid the cycle after rd_en)
   logic              rd_valid;
   logic [ADDR_W-1:0] rd_row;

   // Write tracking pipe: a row presented on arr_in comes back from the
   // array as a next-state row LAT+1 cycles later (the array needs the row
   // below before it can resolve the row itself).
   logic              wv_pipe [0:LAT];
   logic [ADDR_W-1:0] wi_pipe [0:LAT];

   // The array is held clear during reset and during the CLEAR step, which
   // gives the zero row above the top of the frame.
   assign arr_rst = rst | (state == S_CLEAR);
   assign arr_in  = rd_valid ? rd_data : '0;
   assign wr_en   = wv_pipe[LAT];
   assign wr_addr = wi_pipe[LAT];
   assign wr_data = arr_out;

   // Sequencing FSM: clear array, read all rows, wait for the last write, pulse done
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         rd_en   <= 1'b0;
         rd_addr <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_CLEAR;
                  busy  <= 1'b1;
               end
            end
            S_CLEAR: begin
               state   <= S_FEED;
               rd_en   <= 1'b1;
               rd_addr <= '0;
            end
            S_FEED: begin
               if (rd_addr == LAST_ROW) begin
                  rd_en <= 1'b0;
                  state <= S_FLUSH;
               end else begin
                  rd_addr <= rd_addr + 1'b1;
               end
            end
            S_FLUSH: begin
               // arr_in is already zero here: that is the bottom padding row
               if (wr_en && (wr_addr == LAST_ROW)) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            S_DONE: begin
               // start is deliberately not looked at here
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               rd_en <= 1'b0;
            end
         endcase
      end
   end

   // Track which row the RAM is returning onto arr_in this cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid <= 1'b0;
         rd_row   <= '0;
      end else begin
         rd_valid <= rd_en;
         rd_row   <= rd_addr;
      end
   end

   // Delay the presented-row valid/index by LAT+1 cycles to drive the write port
   always_ff @(posedge clk) begin
      if (rst || (state == S_CLEAR)) begin
         for (int i = 0; i <= LAT; i++) begin
            wv_pipe[i] <= 1'b0;
            wi_pipe[i] <= '0;
         end
      end else begin
         wv_pipe[0] <= rd_valid;
         wi_pipe[0] <= rd_row;
         for (int i = 1; i <= LAT; i++) begin
            wv_pipe[i] <= wv_pipe[i-1];
            wi_pipe[i] <= wi_pipe[i-1];
         end
      end
   end

endmodule
